// File: rtl/ualink_pkt_checker.sv
// AXI4-Stream sink that checks the fixed ualink_turbo64 test packet format
// (two header beats plus incrementing payload) and keeps good/bad packet counts.
module ualink_pkt_checker #(
   parameter int          C_S_AXIS_DATA_WIDTH = 64,
   parameter logic [63:0] EXP_HDR0            = 64'hEFBEFECAFECAFECA,
   parameter logic [63:0] EXP_HDR1            = 64'h00000008EFBEEFBE,
   parameter int          PAYLOAD_WORDS       = 32,
   parameter int          COUNT_WIDTH         = 32
) (
   input  logic                             axi_aclk,
   input  logic                             reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic                             s_axis_tlast,
   input  logic                             stall,
   input  logic                             clear_counters,
   output logic                             pkt_done,
   output logic                             pkt_ok,
   output logic [2:0]                       err_code,
   output logic [7:0]                       err_word_idx,
   output logic [COUNT_WIDTH-1:0]           good_cnt,
   output logic [COUNT_WIDTH-1:0]           bad_cnt,
   output logic                             busy
);

   // state   | meaning
   // IDLE    | expecting beat 0 (destination MAC header)
   // HDR1    | expecting beat 1 (source MAC + EtherType)
   // PAYLOAD | expecting payload beat idx-2, byte value replicated 8 times
   // DROP    | overlong packet, discarding unchecked beats until tlast
   typedef enum logic [1:0] {S_IDLE, S_HDR1, S_PAYLOAD, S_DROP} state_t;

   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_HDR0  = 3'd1;
   localparam logic [2:0] E_HDR1  = 3'd2;
   localparam logic [2:0] E_DATA  = 3'd3;
   localparam logic [2:0] E_SHORT = 3'd4;
   localparam logic [2:0] E_LONG  = 3'd5;
   localparam logic [2:0] E_STRB  = 3'd6;

   localparam logic [7:0]             LAST_IDX = 8'(PAYLOAD_WORDS + 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

   state_t     state;
   logic [7:0] idx;
   logic [2:0] pend_err;
   logic [7:0] pend_idx;

   logic       beat;
   logic [7:0] pay_byte;
   logic       data_bad;
   logic [2:0] beat_err;
   logic [2:0] cur_err;
   logic [7:0] cur_idx;
   logic [2:0] first_err;
   logic [7:0] first_idx;

   assign s_axis_tready = ~stall & ~reset;
   assign beat          = s_axis_tvalid & s_axis_tready;
   assign busy          = (state != S_IDLE);
   assign pay_byte      = idx - 8'd2;

   always_comb begin
      data_bad = 1'b0;
      case (state)
         S_IDLE:    data_bad = (s_axis_tdata != EXP_HDR0);
         S_HDR1:    data_bad = (s_axis_tdata != EXP_HDR1);
         S_PAYLOAD: data_bad = (s_axis_tdata != {8{pay_byte}});
         default:   data_bad = 1'b0;
      endcase
   end

   // Per-beat error in priority order; beats in DROP are never checked.
   always_comb begin
      beat_err = E_NONE;
      if (state != S_DROP) begin
         if (s_axis_tstrb != '1)
            beat_err = E_STRB;
         else if (data_bad)
            beat_err = (state == S_IDLE) ? E_HDR0 : (state == S_HDR1) ? E_HDR1 : E_DATA;
         else if (s_axis_tlast && idx != LAST_IDX)
            beat_err = E_SHORT;
         else if (!s_axis_tlast && idx == LAST_IDX)
            beat_err = E_LONG;
      end
   end

   // Beat 0 always starts a fresh packet, so any stale pending error is ignored.
   always_comb begin
      cur_err   = (state == S_IDLE) ? E_NONE : pend_err;
      cur_idx   = (state == S_IDLE) ? 8'd0   : pend_idx;
      first_err = (cur_err != E_NONE) ? cur_err : beat_err;
      first_idx = (cur_err != E_NONE) ? cur_idx : ((beat_err != E_NONE) ? idx : 8'd0);
   end

   always_ff @(posedge axi_aclk) begin
      if (reset) begin
         state        <= S_IDLE;
         idx          <= 8'd0;
         pend_err     <= E_NONE;
         pend_idx     <= 8'd0;
         pkt_done     <= 1'b0;
         pkt_ok       <= 1'b0;
         err_code     <= E_NONE;
         err_word_idx <= 8'd0;
         good_cnt     <= '0;
         bad_cnt      <= '0;
      end else begin
         pkt_done <= 1'b0;
         pkt_ok   <= 1'b0;
         if (beat) begin
            if (s_axis_tlast) begin
               state        <= S_IDLE;
               idx          <= 8'd0;
               pend_err     <= E_NONE;
               pend_idx     <= 8'd0;
               pkt_done     <= 1'b1;
               pkt_ok       <= (first_err == E_NONE);
               err_code     <= first_err;
               err_word_idx <= first_idx;
            end else begin
               pend_err <= first_err;
               pend_idx <= first_idx;
               if (state != S_DROP)
                  idx <= idx + 8'd1;
               case (state)
                  S_IDLE:    state <= S_HDR1;
                  S_HDR1:    state <= S_PAYLOAD;
                  S_PAYLOAD: state <= (idx == LAST_IDX) ? S_DROP : S_PAYLOAD;
                  default:   state <= S_DROP;
               endcase
            end
         end
         if (clear_counters) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
         end else if (beat && s_axis_tlast) begin
            if (first_err == E_NONE) begin
               if (good_cnt != CNT_MAX)
                  good_cnt <= good_cnt + CNT_ONE;
            end else if (bad_cnt != CNT_MAX) begin
               bad_cnt <= bad_cnt + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_ualink_pkt_checker.sv
// Bench for ualink_pkt_checker: directed test-plan packets plus randomized packets
// scored against a packet-level reference model.
module tb_ualink_pkt_checker;

   localparam int          PW    = 32;
   localparam int          CW    = 2;
   localparam int          MAXC  = (1 << CW) - 1;
   localparam logic [63:0] HDR0  = 64'hEFBEFECAFECAFECA;
   localparam logic [63:0] HDR1  = 64'h00000008EFBEEFBE;
   localparam int          NOM   = PW + 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [63:0]   s_axis_tdata;
   logic [7:0]    s_axis_tstrb;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic          stall;
   logic          clear_counters;
   logic          pkt_done;
   logic          pkt_ok;
   logic [2:0]    err_code;
   logic [7:0]    err_word_idx;
   logic [CW-1:0] good_cnt;
   logic [CW-1:0] bad_cnt;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int spurious = 0;
   int gm = 0;
   int bm = 0;

   logic [63:0] pd[$];
   logic [7:0]  ps[$];
   bit          pl[$];
   logic [63:0] saved[$];

   ualink_pkt_checker #(
      .C_S_AXIS_DATA_WIDTH(64), .EXP_HDR0(HDR0), .EXP_HDR1(HDR1),
      .PAYLOAD_WORDS(PW), .COUNT_WIDTH(CW)
   ) dut (
      .axi_aclk(clk), .reset(reset), .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .stall(stall), .clear_counters(clear_counters), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
      .err_code(err_code), .err_word_idx(err_word_idx), .good_cnt(good_cnt), .bad_cnt(bad_cnt),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_word(input int i);
      logic [7:0] b;
      if (i == 0) return HDR0;
      if (i == 1) return HDR1;
      b = 8'(i - 2);
      return {8{b}};
   endfunction

   task automatic build(input int n);
      pd.delete(); ps.delete(); pl.delete();
      for (int i = 0; i < n; i++) begin
         pd.push_back((i <= PW + 1) ? exp_word(i) : {$urandom, $urandom});
         ps.push_back(8'hFF);
         pl.push_back(1'b0);
      end
      pl[n-1] = 1'b1;
   endtask

   // Reference: scan the packet beat by beat and report the first rule it breaks.
   task automatic ref_check(output logic [2:0] e, output logic [7:0] wi);
      e = 3'd0; wi = 8'd0;
      for (int i = 0; i < pd.size() && i <= PW + 1; i++) begin
         logic [2:0] be;
         be = 3'd0;
         if (ps[i] != 8'hFF) be = 3'd6;
         else if (pd[i] != exp_word(i)) be = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : 3'd3;
         else if (pl[i] && i < PW + 1) be = 3'd4;
         else if (!pl[i] && i == PW + 1) be = 3'd5;
         if (be != 3'd0 && e == 3'd0) begin
            e = be; wi = 8'(i);
         end
      end
   endtask

   task automatic send(input bit bp, input bit gaps, input bit clr, output int cyc);
      int  i;
      bit  gap;
      i = 0; cyc = 0;
      while (i < pd.size() && cyc < 2000) begin
         @(negedge clk);
         if (pkt_done) spurious++;
         stall = bp ? cyc[0] : 1'b0;
         gap = gaps && ($urandom_range(0, 3) == 0);
         if (gap) begin
            s_axis_tvalid = 1'b0; s_axis_tdata = {$urandom, $urandom};
            s_axis_tstrb = 8'($urandom); s_axis_tlast = 1'($urandom);
         end else begin
            s_axis_tvalid = 1'b1; s_axis_tdata = pd[i]; s_axis_tstrb = ps[i]; s_axis_tlast = pl[i];
         end
         clear_counters = clr && !gap && !stall && (i == pd.size() - 1);
         @(posedge clk);
         cyc++;
         if (!gap && !stall) i++;
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; stall = 1'b0; clear_counters = 1'b0;
      chk("send_complete", 64'(i), 64'(pd.size()));
   endtask

   task automatic check_done(input bit clr);
      logic [2:0] e;
      logic [7:0] wi;
      ref_check(e, wi);
      if (clr) begin gm = 0; bm = 0; end
      else if (e == 3'd0) gm = (gm == MAXC) ? MAXC : gm + 1;
      else bm = (bm == MAXC) ? MAXC : bm + 1;
      chk("pkt_done", 64'(pkt_done), 64'(1));
      chk("pkt_ok", 64'(pkt_ok), 64'(e == 3'd0));
      chk("err_code", 64'(err_code), 64'(e));
      chk("err_word_idx", 64'(err_word_idx), 64'(wi));
      chk("good_cnt", 64'(good_cnt), 64'(gm));
      chk("bad_cnt", 64'(bad_cnt), 64'(bm));
      chk("busy_after", 64'(busy), 64'(0));
      chk("no_early_done", 64'(spurious), 64'(0));
      @(negedge clk);
      chk("done_pulse_end", 64'(pkt_done), 64'(0));
      chk("err_code_hold", 64'(err_code), 64'(e));
   endtask

   initial begin
      int cyc;
      int n;
      int kind;
      reset = 1'b1; s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0; stall = 1'b0; clear_counters = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", 64'(s_axis_tready), 64'(0));
      chk("rst_pkt_done", 64'(pkt_done), 64'(0));
      chk("rst_good", 64'(good_cnt), 64'(0));
      chk("rst_bad", 64'(bad_cnt), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err", 64'({err_code, err_word_idx, pkt_ok}), 64'(0));
      reset = 1'b0;
      #1 chk("tready_up", 64'(s_axis_tready), 64'(1));
      stall = 1'b1;
      #1 chk("tready_stall", 64'(s_axis_tready), 64'(0));
      stall = 1'b0;

      // nominal
      build(NOM); send(0, 0, 0, cyc); check_done(0);
      // backpressure: stall toggles every cycle, accepted on alternate cycles
      build(NOM); send(1, 0, 0, cyc);
      chk("bp_cycles", 64'(cyc), 64'(2 * NOM - 1));
      check_done(0);
      // corruption at payload 5 and 10
      build(NOM); pd[7] = {8{8'h06}}; pd[12] = ~pd[12]; send(0, 0, 0, cyc); check_done(0);
      // short and long, each followed by a good packet
      build(19); send(0, 0, 0, cyc); check_done(0);
      build(NOM); send(0, 0, 0, cyc); check_done(0);
      build(NOM + 3); send(0, 0, 0, cyc); check_done(0);
      build(NOM); send(0, 0, 0, cyc); check_done(0);
      // strobe error takes priority over a header mismatch on the same beat
      build(NOM); ps[0] = 8'h0F; pd[0] = ~HDR0; send(0, 0, 0, cyc); check_done(0);
      // tlast on beat 0 alone
      build(1); send(0, 0, 0, cyc); check_done(0);

      // reset in the middle of payload beat 12
      build(NOM);
      saved = pd;
      pd.delete(); ps.delete(); pl.delete();
      for (int i = 0; i < 14; i++) begin pd.push_back(saved[i]); ps.push_back(8'hFF); pl.push_back(1'b0); end
      send(0, 0, 0, cyc);
      chk("partial_busy", 64'(busy), 64'(1));
      chk("partial_no_done", 64'(pkt_done), 64'(0));
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_tready", 64'(s_axis_tready), 64'(0));
      reset = 1'b0;
      gm = 0; bm = 0;
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_done", 64'(pkt_done), 64'(0));
      chk("rst_mid_cnt", 64'({good_cnt, bad_cnt}), 64'(0));
      pd.delete(); ps.delete(); pl.delete();
      for (int i = 14; i < NOM; i++) begin pd.push_back(saved[i]); ps.push_back(8'hFF); pl.push_back(i == NOM - 1); end
      send(0, 0, 0, cyc); check_done(0);

      // randomized packets
      for (int k = 0; k < 30; k++) begin
         kind = $urandom_range(0, 5);
         n = NOM;
         if (kind == 2 || kind == 5) n = $urandom_range(1, NOM - 1);
         if (kind == 3) n = NOM + $urandom_range(1, 5);
         build(n);
         if (kind == 1 || kind == 5) begin
            for (int c = 0; c < 2; c++) begin
               int p;
               p = $urandom_range(0, n - 1);
               pd[p] = pd[p] ^ {$urandom | 32'h1, $urandom};
            end
         end
         if (kind == 4) ps[$urandom_range(0, n - 1)] = 8'($urandom_range(0, 254));
         send(1'($urandom), 1'($urandom), 0, cyc);
         check_done(0);
      end

      // counter clear alone, then saturation, then clear coinciding with an increment
      @(negedge clk);
      clear_counters = 1'b1;
      @(negedge clk);
      clear_counters = 1'b0;
      gm = 0; bm = 0;
      chk("clear_good", 64'(good_cnt), 64'(0));
      chk("clear_bad", 64'(bad_cnt), 64'(0));
      for (int k = 0; k < 5; k++) begin
         build(NOM); send(0, 0, 0, cyc); check_done(0);
      end
      chk("sat_good", 64'(good_cnt), 64'(MAXC));
      build(NOM); send(0, 0, 1, cyc); check_done(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
